// File: rtl/ghash_pkg.sv
// Shared types and GF(2^128) helpers for the GHASH streaming engine.
// Holds the FSM state enum, the GCM reduction constant and a one-bit multiply step.
// No ports; imported by ghash_stream and gf128_digit_mul.
package ghash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        MUL,
        LEN,
        DONE
    } state_t;

    // GCM reduction polynomial in reflected bit order: 11100001 || 0^120
    localparam logic [127:0] GF_R = 128'hE1 << 120;

    // One shift-and-add step of the GCM multiply: conditionally accumulate V
    // into Z, then divide V by x modulo the field polynomial.
    // Returns {Z', V'}.
    function automatic logic [255:0] gf_step(input logic [127:0] z,
                                             input logic [127:0] v,
                                             input logic         x);
        logic [127:0] z_n;
        logic [127:0] v_n;
        z_n = x ? (z ^ v) : z;
        v_n = v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
        return {z_n, v_n};
    endfunction

endpackage

// File: rtl/gf128_digit_mul.sv
// Combinational DIGIT-bit slice of the GCM multiply: applies DIGIT gf_step stages.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller sequences the slices.
// Ports: i_z/i_v running product and shifted subkey, i_x_bits next multiplier
//        bits (MSB = first in GCM order), o_z/o_v updated product and subkey.
module gf128_digit_mul
    import ghash_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [127:0]      i_z,
    input  logic [127:0]      i_v,
    input  logic [DIGIT-1:0]  i_x_bits,
    output logic [127:0]      o_z,
    output logic [127:0]      o_v
);

    logic [127:0] w_z [0:DIGIT];
    logic [127:0] w_v [0:DIGIT];

    assign w_z[0] = i_z;
    assign w_v[0] = i_v;

    for (genvar g = 0; g < DIGIT; g++) begin : g_step
        logic [255:0] w_zv;
        // Bits are consumed MSB first, matching GCM's bit ordering.
        assign w_zv       = gf_step(w_z[g], w_v[g], i_x_bits[DIGIT-1-g]);
        assign w_z[g+1]   = w_zv[255:128];
        assign w_v[g+1]   = w_zv[127:0];
    end

    assign o_z = w_z[DIGIT];
    assign o_v = w_v[DIGIT];

endmodule

// File: rtl/ghash_stream.sv
// Streaming GCM GHASH + tag: absorbs AAD/CT blocks, appends the length block, emits S ^ E_K(J0).
// Latency: 128/DIGIT+1 cycles per block; finish accept to tag_valid is 128/DIGIT+2 cycles.
// Backpressure: blk_ready only in WAIT; blocks and finish are held off during LEN/MUL/DONE/IDLE.
// Ports: clk/rst, h + ek_j0 (sampled on start), start, blk_data/blk_type/blk_bytes/blk_valid,
//        blk_ready, finish, tag/tag_valid (held until next start), err (sticky order error), busy.
module ghash_stream
    import ghash_pkg::*;
#(
    parameter int DIGIT = 8,
    parameter int LEN_W = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] h,
    input  logic [127:0] ek_j0,
    input  logic         start,
    input  logic [127:0] blk_data,
    input  logic         blk_type,
    input  logic [4:0]   blk_bytes,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic         finish,
    output logic [127:0] tag,
    output logic         tag_valid,
    output logic         err,
    output logic         busy
);

    localparam int NCYC  = 128 / DIGIT;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_t             r_state;
    logic [127:0]       r_h;
    logic [127:0]       r_ek;
    logic [127:0]       r_s;      // accumulator; doubles as the multiplier shift register during MUL
    logic [127:0]       r_z;
    logic [127:0]       r_v;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_from_len;
    logic [LEN_W-1:0]   r_aad_len;
    logic [LEN_W-1:0]   r_ct_len;
    logic [127:0]       r_tag;
    logic               r_tag_valid;
    logic               r_err;

    logic [4:0]         w_nbytes;
    logic [127:0]       w_mask;
    logic [127:0]       w_len_blk;
    logic               w_order_err;
    logic               w_last;
    logic [127:0]       w_z_nxt;
    logic [127:0]       w_v_nxt;

    function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a,
                                                 input logic [4:0]       b);
        logic [LEN_W:0] s;
        s = {1'b0, a} + (LEN_W+1)'(b);
        return s[LEN_W] ? '1 : s[LEN_W-1:0];
    endfunction

    // 0 means a full block; out-of-range counts are also clamped to a full block.
    assign w_nbytes    = (blk_bytes == 5'd0 || blk_bytes > 5'd16) ? 5'd16 : blk_bytes;
    // Keep bytes [0, n): those sit at the top of the word.
    assign w_mask      = ~({128{1'b1}} >> {w_nbytes, 3'b000});
    assign w_len_blk   = {(64'(r_aad_len) << 3), (64'(r_ct_len) << 3)};
    // Every accepted CT block adds at least one byte, so a non-zero CT count means CT was seen.
    assign w_order_err = !blk_type && (r_ct_len != '0);
    assign w_last      = (r_cnt == CNT_W'(NCYC - 1));

    gf128_digit_mul #(.DIGIT(DIGIT)) u_mul (
        .i_z      (r_z),
        .i_v      (r_v),
        .i_x_bits (r_s[127 -: DIGIT]),
        .o_z      (w_z_nxt),
        .o_v      (w_v_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_h         <= '0;
            r_ek        <= '0;
            r_s         <= '0;
            r_z         <= '0;
            r_v         <= '0;
            r_cnt       <= '0;
            r_from_len  <= 1'b0;
            r_aad_len   <= '0;
            r_ct_len    <= '0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_err       <= 1'b0;
        end else if (start) begin
            r_h         <= h;
            r_ek        <= ek_j0;
            r_s         <= '0;
            r_aad_len   <= '0;
            r_ct_len    <= '0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_err       <= 1'b0;
            r_state     <= WAIT;
        end else begin
            case (r_state)
                WAIT: begin
                    if (blk_valid) begin
                        if (w_order_err) begin
                            // Late AAD block is consumed and dropped; no state change besides err.
                            r_err <= 1'b1;
                        end else begin
                            r_s <= r_s ^ (blk_data & w_mask);
                            if (blk_type) r_ct_len  <= sat_add(r_ct_len, w_nbytes);
                            else          r_aad_len <= sat_add(r_aad_len, w_nbytes);
                            r_z        <= '0;
                            r_v        <= r_h;
                            r_cnt      <= '0;
                            r_from_len <= 1'b0;
                            r_state    <= MUL;
                        end
                    end else if (finish) begin
                        r_s     <= r_s ^ w_len_blk;
                        r_state <= LEN;
                    end
                end
                LEN: begin
                    r_z        <= '0;
                    r_v        <= r_h;
                    r_cnt      <= '0;
                    r_from_len <= 1'b1;
                    r_state    <= MUL;
                end
                MUL: begin
                    r_z <= w_z_nxt;
                    r_v <= w_v_nxt;
                    if (w_last) begin
                        r_s <= w_z_nxt;
                        if (r_from_len) begin
                            r_tag       <= w_z_nxt ^ r_ek;
                            r_tag_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end else begin
                        r_s   <= r_s << DIGIT;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= r_state;  // IDLE and DONE wait for start
            endcase
        end
    end

    assign blk_ready = (r_state == WAIT);
    assign busy      = (r_state != IDLE) && (r_state != DONE);
    assign tag       = r_tag;
    assign tag_valid = r_tag_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_ghash_stream.sv
// Directed bench for ghash_stream at DIGIT = 1, 8 and 128 using GCM known-answer vectors.
// Latency: checks block period and finish-to-tag latency against 128/DIGIT.
// Backpressure: waits on blk_ready with bounded loops.
module tb_ghash_stream;

    localparam int NDUT = 3;

    localparam logic [127:0] H1  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EK1 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] C1  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] T1  = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [127:0] H3  = 128'hb83b533708bf535d0aa6e52980d53b78;
    localparam logic [127:0] EK3 = 128'h3247184b3c4f69a44dbcd22887bbb418;
    localparam logic [127:0] C3  = 128'h42831ec2217774244b7221b784d0d49c;
    localparam logic [127:0] T3  = 128'h57926dde92a5c01ee854dc9b33ebc856;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] h, ek_j0, blk_data;
    logic         blk_type;
    logic [4:0]   blk_bytes;

    logic         start_a     [NDUT];
    logic         blk_valid_a [NDUT];
    logic         finish_a    [NDUT];
    logic         blk_ready_a [NDUT];
    logic         tag_valid_a [NDUT];
    logic         err_a       [NDUT];
    logic         busy_a      [NDUT];
    logic [127:0] tag_a       [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ghash_stream #(.DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .h(h), .ek_j0(ek_j0), .start(start_a[0]),
        .blk_data(blk_data), .blk_type(blk_type), .blk_bytes(blk_bytes),
        .blk_valid(blk_valid_a[0]), .blk_ready(blk_ready_a[0]), .finish(finish_a[0]),
        .tag(tag_a[0]), .tag_valid(tag_valid_a[0]), .err(err_a[0]), .busy(busy_a[0]));

    ghash_stream #(.DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .h(h), .ek_j0(ek_j0), .start(start_a[1]),
        .blk_data(blk_data), .blk_type(blk_type), .blk_bytes(blk_bytes),
        .blk_valid(blk_valid_a[1]), .blk_ready(blk_ready_a[1]), .finish(finish_a[1]),
        .tag(tag_a[1]), .tag_valid(tag_valid_a[1]), .err(err_a[1]), .busy(busy_a[1]));

    ghash_stream #(.DIGIT(128)) u_d128 (
        .clk(clk), .rst(rst), .h(h), .ek_j0(ek_j0), .start(start_a[2]),
        .blk_data(blk_data), .blk_type(blk_type), .blk_bytes(blk_bytes),
        .blk_valid(blk_valid_a[2]), .blk_ready(blk_ready_a[2]), .finish(finish_a[2]),
        .tag(tag_a[2]), .tag_valid(tag_valid_a[2]), .err(err_a[2]), .busy(busy_a[2]));

    function automatic int ncyc(input int k);
        case (k)
            0:       return 128;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    // Textbook bit-serial GCM multiply, used only for the partial-block expectation.
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z = '0;
        logic [127:0] v = y;
        for (int i = 127; i >= 0; i--) begin
            if (x[i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'hE1, 120'd0}) : (v >> 1);
        end
        return z;
    endfunction

    task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int k, input logic [127:0] hv, input logic [127:0] ev);
        h = hv;
        ek_j0 = ev;
        start_a[k] = 1'b1;
        step();
        start_a[k] = 1'b0;
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (!blk_ready_a[k] && n < 300) begin
            step();
            n++;
        end
        check_val("ready_wait", 128'(blk_ready_a[k]), 128'd1);
    endtask

    // Returns cycles from the accept cycle until blk_ready is back.
    task automatic send_block(input int k, input logic [127:0] d, input logic t,
                              input logic [4:0] nb, output int cyc);
        wait_ready(k);
        blk_data = d;
        blk_type = t;
        blk_bytes = nb;
        blk_valid_a[k] = 1'b1;
        step();
        blk_valid_a[k] = 1'b0;
        cyc = 1;
        while (!blk_ready_a[k] && cyc < 300) begin
            step();
            cyc++;
        end
    endtask

    // Returns cycles from the finish-accept cycle until tag_valid.
    task automatic do_finish(input int k, output int cyc);
        wait_ready(k);
        finish_a[k] = 1'b1;
        step();
        finish_a[k] = 1'b0;
        cyc = 1;
        while (!tag_valid_a[k] && cyc < 300) begin
            step();
            cyc++;
        end
    endtask

    task automatic check_idle_outputs(input int k, input string pfx);
        check_val({pfx, "_ready"}, 128'(blk_ready_a[k]), 128'd0);
        check_val({pfx, "_busy"},  128'(busy_a[k]),      128'd0);
        check_val({pfx, "_tvld"},  128'(tag_valid_a[k]), 128'd0);
        check_val({pfx, "_err"},   128'(err_a[k]),       128'd0);
        check_val({pfx, "_tag"},   tag_a[k],             128'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [127:0] part_blk, part_exp;

        rst = 1'b1;
        h = '0; ek_j0 = '0; blk_data = '0; blk_type = 1'b0; blk_bytes = 5'd0;
        for (int k = 0; k < NDUT; k++) begin
            start_a[k] = 1'b0;
            blk_valid_a[k] = 1'b0;
            finish_a[k] = 1'b0;
        end
        step();
        step();
        for (int k = 0; k < NDUT; k++) check_idle_outputs(k, $sformatf("reset_d%0d", k));
        rst = 1'b0;
        step();

        // Empty message: tag equals E_K(J0)
        do_start(1, H1, EK1);
        check_val("wait_busy", 128'(busy_a[1]), 128'd1);
        do_finish(1, cyc);
        check_val("empty_tag", tag_a[1], EK1);
        check_val("empty_lat", 128'(cyc), 128'(ncyc(1) + 2));
        check_val("done_busy", 128'(busy_a[1]), 128'd0);

        // One CT block across all digit widths
        for (int k = 0; k < NDUT; k++) begin
            do_start(k, H1, EK1);
            send_block(k, C1, 1'b1, 5'd16, cyc);
            check_val($sformatf("tc2_period_d%0d", k), 128'(cyc), 128'(ncyc(k) + 1));
            do_finish(k, cyc);
            check_val($sformatf("tc2_lat_d%0d", k), 128'(cyc), 128'(ncyc(k) + 2));
            check_val($sformatf("tc2_tag_d%0d", k), tag_a[k], T1);
        end

        // Second key, blk_bytes=0 meaning a full block
        do_start(1, H3, EK3);
        send_block(1, C3, 1'b1, 5'd0, cyc);
        do_finish(1, cyc);
        check_val("tc3_tag", tag_a[1], T3);

        // Ordering error: AAD after CT is dropped, err sticks until start
        do_start(1, H1, EK1);
        send_block(1, C1, 1'b1, 5'd16, cyc);
        send_block(1, 128'hdeadbeef_00112233_44556677_8899aabb, 1'b0, 5'd16, cyc);
        check_val("order_err", 128'(err_a[1]), 128'd1);
        check_val("order_ready", 128'(blk_ready_a[1]), 128'd1);
        check_val("order_cyc", 128'(cyc), 128'd1);
        do_finish(1, cyc);
        check_val("order_tag", tag_a[1], T1);
        check_val("order_sticky", 128'(err_a[1]), 128'd1);
        do_start(1, H1, EK1);
        check_val("order_clear", 128'(err_a[1]), 128'd0);

        // Partial block: the non-zero tail must be masked away
        part_blk = {C1[127:88], 88'hffffffffffffffffffffff};
        part_exp = gf_mul(gf_mul({C1[127:88], 88'd0}, H1) ^ {64'd0, 64'd40}, H1) ^ EK1;
        send_block(1, part_blk, 1'b1, 5'd5, cyc);
        check_val("part_ctlen", 128'(u_d8.r_ct_len), 128'd5);
        do_finish(1, cyc);
        check_val("part_tag", tag_a[1], part_exp);

        // blk_valid and finish together: block wins, no tag yet
        do_start(1, H1, EK1);
        wait_ready(1);
        blk_data = C1; blk_type = 1'b1; blk_bytes = 5'd16;
        blk_valid_a[1] = 1'b1;
        finish_a[1] = 1'b1;
        step();
        blk_valid_a[1] = 1'b0;
        finish_a[1] = 1'b0;
        check_val("coll_busy", 128'(busy_a[1]), 128'd1);
        wait_ready(1);
        check_val("coll_notag", 128'(tag_valid_a[1]), 128'd0);
        do_finish(1, cyc);
        check_val("coll_tag", tag_a[1], T1);

        // Reset in the middle of a multiply
        do_start(0, H1, EK1);
        wait_ready(0);
        blk_data = C1; blk_type = 1'b1; blk_bytes = 5'd16;
        blk_valid_a[0] = 1'b1;
        step();
        blk_valid_a[0] = 1'b0;
        step();
        step();
        check_val("mid_busy", 128'(busy_a[0]), 128'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs(0, "mid_rst");
        step();
        rst = 1'b0;
        blk_valid_a[0] = 1'b1;
        step();
        step();
        step();
        check_val("post_rst_refuse", 128'(blk_ready_a[0]), 128'd0);
        check_val("post_rst_busy", 128'(busy_a[0]), 128'd0);
        blk_valid_a[0] = 1'b0;
        do_start(0, H1, EK1);
        send_block(0, C1, 1'b1, 5'd16, cyc);
        check_val("post_rst_period", 128'(cyc), 128'(ncyc(0) + 1));
        do_finish(0, cyc);
        check_val("post_rst_tag", tag_a[0], T1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ghash_stream.md
GHASH_STREAM -- requirements
Module: ghash_stream

Interface
REQ-001 Parameter DIGIT, default 8: GF(2^128) multiplier bits processed per cycle; legal values 1,2,4,8,16,32,64,128.
REQ-002 Parameter LEN_W, default 36: width of each byte-length counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 h  in  128  hash subkey E_K(0^128); sampled on the start cycle.
REQ-006 ek_j0  in  128  E_K(J0); sampled on the start cycle.
REQ-007 start  in  1  one-cycle pulse that begins a new message.
REQ-008 blk_data  in  128  input block, byte 0 = bits [127:120].
REQ-009 blk_type  in  1  0 = AAD block, 1 = ciphertext block.
REQ-010 blk_bytes  in  5  valid bytes 1..16; 0 is treated as 16.
REQ-011 blk_valid  in  1  block offer.
REQ-012 blk_ready  out  1  block/finish acceptance.
REQ-013 finish  in  1  end of message; triggers the length block.
REQ-014 tag  out  128  final tag, GHASH ^ ek_j0.
REQ-015 tag_valid  out  1  tag is valid.
REQ-016 err  out  1  ordering violation, sticky.
REQ-017 busy  out  1  high in all states except IDLE and DONE.

Function
REQ-018 FSM states: IDLE, WAIT, MUL, LEN, DONE.
REQ-019 start from any state: latch h and ek_j0; clear accumulator S, both length counters, err and tag_valid; go to WAIT.
REQ-020 blk_ready = 1 only in WAIT. A block transfers when blk_valid && blk_ready.
REQ-021 Block accept: zero the bytes at index >= blk_bytes; S <= S ^ masked block; add blk_bytes to the AAD or CT counter per blk_type; go to MUL.
REQ-022 MUL: S <= S*H, MSB-first per GCM bit order, DIGIT bits per cycle, reduction polynomial R = 0xE1 || 0^120.
REQ-023 MUL lasts exactly 128/DIGIT cycles, then returns to WAIT (or to DONE if the multiply came from LEN).
REQ-024 finish is accepted in WAIT only when blk_valid is low. If both are asserted, the block is accepted and finish is ignored.
REQ-025 Finish accept: S <= S ^ {aad_bytes*8 (64b, zero-extended), ct_bytes*8 (64b)}; enter LEN for one cycle, then MUL.
REQ-026 On leaving the final MUL: tag <= S ^ ek_j0; tag_valid = 1; state DONE. Both are held until the next start or rst.
REQ-027 An AAD block accepted after any CT block in the same message sets err=1. The block is discarded (S and counters unchanged) and no MUL occurs; the FSM stays in WAIT.
REQ-028 Length counters saturate at all-ones and do not wrap.
REQ-029 blk_valid and finish are ignored in IDLE, MUL, LEN and DONE.
REQ-030 Throughput: one block per 128/DIGIT+1 cycles. Latency from finish accept to tag_valid: 128/DIGIT+2 cycles.

Reset
REQ-031 rst asynchronously forces IDLE, and tag, S, counters, latched h and ek_j0 to zero, with tag_valid=0, err=0, blk_ready=0, busy=0.
REQ-032 rst mid-MUL aborts the message. The first block after reset is refused until start is asserted.

Structure
REQ-033 Package ghash_pkg holds the FSM state enum, the constant GF_R = 128'hE1<<120, and the function gf_step (one bit of shift-and-reduce).
REQ-034 One sub-module, gf128_digit_mul: combinational DIGIT-bit step (Z,V,x_bits) -> (Z',V'), instantiated once.

Verification
REQ-035 Empty message: h=66e94bd4ef8a2c3b884cfa59ca342b2e, ek_j0=58e2fccefa7e3061367f1d57a4e7455a; start then finish -> tag=58e2fccefa7e3061367f1d57a4e7455a.
REQ-036 Same h/ek_j0, one CT block 0388dace60b6a392f328c2b971b2fe78, then finish -> tag=ab6e47d42cec13bdf53a67b21257bddf. Run for DIGIT = 1, 8 and 128, and check the cycle count against REQ-030.
REQ-037 h=b83b533708bf535d0aa6e52980d53b78, ek_j0=3247184b3c4f69a44dbcd22887bbb418, CT block 42831ec2217774244b7221b784d0d49c -> tag=57926dde92a5c01ee854dc9b33ebc856.
REQ-038 Ordering error: CT block followed by AAD block -> err=1, S unchanged, blk_ready returns high the next cycle; a subsequent start clears err.
REQ-039 Partial block and collision: blk_bytes=5 with non-zero tail bytes gives the same tag as the zero-tailed block, and ct_bytes=5. blk_valid and finish asserted together -> block taken, no tag.
REQ-040 rst asserted mid-MUL -> all outputs 0 immediately; a full message after a new start matches REQ-036.
